// File: rtl/uart_rx_deserializer.sv
// UART receiver: 2-FF synchronised line, start detection on the oversampling tick,
// 2-of-3 mid-bit majority vote, LSB-first deserialisation, optional parity, valid/ready output.
module uart_rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sample_tick_i,
    input  logic       rx_i,
    input  logic       rx_ready_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       framing_error_o,
    output logic       parity_error_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [TCW-1:0] TC_V0   = TCW'(M - 1);
    localparam logic [TCW-1:0] TC_V1   = TCW'(M);
    localparam logic [TCW-1:0] TC_V2   = TCW'(M + 1);
    localparam logic [2:0]     IDX_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t         state_q, state_d;
    logic           rx_meta_q, rx_s_q;
    logic [TCW-1:0] tc_q, tc_d;
    logic [2:0]     idx_q, idx_d;
    logic           v0_q, v0_d, v1_q, v1_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           fe_q, fe_d;
    logic           pe_q, pe_d;
    logic           ovr_q, ovr_d;

    logic           maj, tc_wrap, accept, complete, frame_fe, frame_pe;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            tc_q      <= '0;
            idx_q     <= '0;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            tc_q      <= tc_d;
            idx_q     <= idx_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            ovr_q     <= ovr_d;
        end
    end

    // Third vote is the live synchronised sample at tc = M+1.
    assign maj     = (v0_q & v1_q) | (v0_q & rx_s_q) | (v1_q & rx_s_q);
    assign tc_wrap = (tc_q == TC_LAST);
    assign accept  = valid_q & rx_ready_i;

    always_comb begin
        state_d  = state_q;
        tc_d     = tc_q;
        idx_d    = idx_q;
        v0_d     = v0_q;
        v1_d     = v1_q;
        shift_d  = shift_q;
        par_d    = par_q;
        data_d   = data_q;
        valid_d  = valid_q;
        fe_d     = fe_q;
        pe_d     = pe_q;
        ovr_d    = 1'b0;
        complete = 1'b0;
        frame_fe = 1'b0;
        frame_pe = (PARITY_EN != 0) && (((^shift_q) ^ par_q) != 1'(PARITY_ODD));

        if (accept) valid_d = 1'b0;

        if (sample_tick_i) begin
            if (state_q != S_IDLE && state_q != S_BREAK) begin
                tc_d = tc_wrap ? '0 : tc_q + 1'b1;
                if (tc_q == TC_V0) v0_d = rx_s_q;
                if (tc_q == TC_V1) v1_d = rx_s_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        tc_d    = '0;
                        shift_d = '0;
                        par_d   = 1'b0;
                    end
                end
                S_START: begin
                    if (tc_q == TC_V2 && maj) begin
                        state_d = S_IDLE;
                    end else if (tc_wrap) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end
                end
                S_DATA: begin
                    if (tc_q == TC_V2) shift_d[idx_q] = maj;
                    if (tc_wrap) begin
                        if (idx_q == IDX_LAST) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        else                   idx_d   = idx_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (tc_q == TC_V2) par_d = maj;
                    if (tc_wrap) state_d = S_STOP;
                end
                S_STOP: begin
                    // Deciding half a bit early leaves time to catch a back-to-back start edge.
                    if (tc_q == TC_V2) begin
                        complete = 1'b1;
                        frame_fe = ~maj;
                        state_d  = (!maj && shift_q == 8'd0) ? S_BREAK : S_IDLE;
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (complete) begin
            if (valid_q && !accept) begin
                ovr_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                data_d  = shift_q;
                fe_d    = frame_fe;
                pe_d    = frame_pe;
            end
        end
    end

    assign rx_data_o       = data_q;
    assign rx_valid_o      = valid_q;
    assign framing_error_o = fe_q;
    assign parity_error_o  = pe_q;
    assign overrun_o       = ovr_q;
    assign busy_o          = (state_q != S_IDLE);

endmodule
